// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the MEM/WB
// pipeline register and a long-latency unit. Long-unit results are queued
// in a small FIFO and drained into cycles where the pipeline does not write.
// A scoreboard reports which registers still have a queued write, and a stall
// request is raised when a queued result has been blocked for too long.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 5,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_wreg,
  input  logic [AW-1:0] wb_wd_addr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_addr,
  input  logic [DW-1:0] lu_data,
  output logic          lu_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] chk_a,
  input  logic [AW-1:0] chk_b,
  input  logic [AW-1:0] chk_d,
  output logic          busy_a,
  output logic          busy_b,
  output logic          busy_d,
  output logic          stallreq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [3:0]    STARVE_C = 4'(STARVE_LIMIT);
  localparam logic [4:0]    STARVE_W = 5'(STARVE_LIMIT);

  logic [AW-1:0] fifo_addr_q [DEPTH];
  logic [AW-1:0] fifo_addr_d [DEPTH];
  logic [DW-1:0] fifo_data_q [DEPTH];
  logic [DW-1:0] fifo_data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    age_q, age_d;
  logic          stall_q, stall_d;

  logic          has_entry;
  logic          push;
  logic          pop;
  logic [4:0]    age_inc;
  logic [PW-1:0] sb_idx;

  // Handshake and queue-movement decisions; lu_ready looks only at registered occupancy.
  always_comb begin
    has_entry = (count_q != '0);
    lu_ready  = (count_q < DEPTH_C) && !rst;
    push      = lu_valid && lu_ready && (lu_addr != '0);
    pop       = !rst && !wb_wreg && has_entry;
  end

  // Write-port mux: pipeline first, then FIFO head, otherwise idle with zeros.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (wb_wreg) begin
        rf_we    = 1'b1;
        rf_waddr = wb_wd_addr;
        rf_wdata = wb_wdata;
      end else if (has_entry) begin
        rf_we    = 1'b1;
        rf_waddr = fifo_addr_q[rd_ptr_q];
        rf_wdata = fifo_data_q[rd_ptr_q];
      end
    end
  end

  // Next-state for FIFO storage, pointers, occupancy, starvation age and stall flag.
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    age_d       = age_q;
    stall_d     = stall_q;
    age_inc     = {1'b0, age_q} + 5'd1;

    if (push) begin
      fifo_addr_d[wr_ptr_q] = lu_addr;
      fifo_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (!has_entry || pop) begin
      age_d = 4'd0;
    end else if (wb_wreg && (age_q < STARVE_C)) begin
      age_d = age_q + 4'd1;
    end

    if (pop) begin
      stall_d = 1'b0;
    end else if (has_entry && wb_wreg && (age_inc >= STARVE_W)) begin
      stall_d = 1'b1;
    end
  end

  // Control state register with synchronous reset; discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
    end
  end

  // FIFO payload storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  // Pending-write scoreboard over valid FIFO entries plus an offered long-unit result.
  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    busy_d = 1'b0;
    sb_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sb_idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (fifo_addr_q[sb_idx] == chk_a) busy_a = 1'b1;
        if (fifo_addr_q[sb_idx] == chk_b) busy_b = 1'b1;
        if (fifo_addr_q[sb_idx] == chk_d) busy_d = 1'b1;
      end
    end
    if (lu_valid) begin
      if (lu_addr == chk_a) busy_a = 1'b1;
      if (lu_addr == chk_b) busy_b = 1'b1;
      if (lu_addr == chk_d) busy_d = 1'b1;
    end
    busy_a = busy_a && (chk_a != '0) && !rst;
    busy_b = busy_b && (chk_b != '0) && !rst;
    busy_d = busy_d && (chk_d != '0) && !rst;
  end

  // Stall request mirrors the registered flag, forced low during reset.
  always_comb begin
    stallreq = stall_q && !rst;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed bench for wb_port_arbiter with DEPTH=2 and
// STARVE_LIMIT=4. Inputs change 1ns after the rising edge; outputs are
// sampled 1ns later, well before the next rising edge.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd_addr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_a;
  logic [4:0]  chk_b;
  logic [4:0]  chk_d;
  logic        busy_a;
  logic        busy_b;
  logic        busy_d;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(
    .DEPTH(2),
    .STARVE_LIMIT(4),
    .AW(5),
    .DW(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_wreg(wb_wreg),
    .wb_wd_addr(wb_wd_addr),
    .wb_wdata(wb_wdata),
    .lu_valid(lu_valid),
    .lu_addr(lu_addr),
    .lu_data(lu_data),
    .lu_ready(lu_ready),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .chk_a(chk_a),
    .chk_b(chk_b),
    .chk_d(chk_d),
    .busy_a(busy_a),
    .busy_b(busy_b),
    .busy_d(busy_d),
    .stallreq(stallreq)
  );

  // 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge, then leave 1ns of margin
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_wreg = 1'b1; wb_wd_addr = 5'd5; wb_wdata = 32'h1;
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h0;
    chk_a = 5'd5; chk_b = 5'd0; chk_d = 5'd0;
    #1;
    // reset state: everything forced low even with active requesters
    check_output("rst_lu_ready", lu_ready, 0);
    check_output("rst_rf_we", rf_we, 0);
    check_output("rst_rf_waddr", rf_waddr, 0);
    check_output("rst_rf_wdata", rf_wdata, 0);
    check_output("rst_busy_a", busy_a, 0);
    check_output("rst_stallreq", stallreq, 0);
    tick();
    tick();
    rst = 1'b0; wb_wreg = 1'b0; wb_wd_addr = 0; wb_wdata = 0;
    lu_valid = 1'b0; lu_addr = 0; chk_a = 0;
    #1;
    check_output("post_rst_lu_ready", lu_ready, 1);
    check_output("post_rst_rf_we", rf_we, 0);

    // idle drain: addr 3 / 0x1234, no bypass
    chk_a = 5'd3; lu_valid = 1'b1; lu_addr = 5'd3; lu_data = 32'h1234;
    #1;
    check_output("drain_busy_offer", busy_a, 1);
    check_output("drain_no_bypass", rf_we, 0);
    tick();
    lu_valid = 1'b0;
    #1;
    check_output("drain_we", rf_we, 1);
    check_output("drain_waddr", rf_waddr, 3);
    check_output("drain_wdata", rf_wdata, 32'h1234);
    check_output("drain_busy_held", busy_a, 1);
    tick();
    check_output("drain_done_we", rf_we, 0);
    check_output("drain_done_busy", busy_a, 0);

    // priority: FIFO holds 7/0xAA while the pipeline writes 2/0x55 twice
    chk_b = 5'd7;
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'hAA;
    wb_wreg = 1'b1; wb_wd_addr = 5'd2; wb_wdata = 32'h55;
    #1;
    check_output("prio1_waddr", rf_waddr, 2);
    check_output("prio1_wdata", rf_wdata, 32'h55);
    tick();
    lu_valid = 1'b0;
    #1;
    check_output("prio2_we", rf_we, 1);
    check_output("prio2_waddr", rf_waddr, 2);
    check_output("prio2_wdata", rf_wdata, 32'h55);
    check_output("prio2_busy_b", busy_b, 1);
    tick();
    wb_wreg = 1'b0;
    #1;
    check_output("prio3_we", rf_we, 1);
    check_output("prio3_waddr", rf_waddr, 7);
    check_output("prio3_wdata", rf_wdata, 32'hAA);
    tick();
    check_output("prio4_we", rf_we, 0);
    check_output("prio4_busy_b", busy_b, 0);

    // back-pressure: pipeline busy, long unit offers 1, 2, 3
    chk_d = 5'd3;
    wb_wreg = 1'b1;
    lu_valid = 1'b1; lu_addr = 5'd1; lu_data = 32'h11;
    #1;
    check_output("bp_ready1", lu_ready, 1);
    tick();
    lu_addr = 5'd2; lu_data = 32'h22;
    #1;
    check_output("bp_ready2", lu_ready, 1);
    tick();
    lu_addr = 5'd3; lu_data = 32'h33;
    #1;
    check_output("bp_full_ready", lu_ready, 0);
    check_output("bp_busy_d_offer", busy_d, 1);
    tick();
    check_output("bp_still_full", lu_ready, 0);
    tick();
    wb_wreg = 1'b0;
    #1;
    check_output("bp_pop_no_same_cycle_ready", lu_ready, 0);
    check_output("bp_head1_addr", rf_waddr, 1);
    check_output("bp_head1_data", rf_wdata, 32'h11);
    check_output("bp_no_stall", stallreq, 0);
    tick();
    check_output("bp_ready_after_pop", lu_ready, 1);
    check_output("bp_head2_addr", rf_waddr, 2);
    check_output("bp_head2_data", rf_wdata, 32'h22);
    tick();
    lu_valid = 1'b0;
    #1;
    check_output("bp_head3_addr", rf_waddr, 3);
    check_output("bp_head3_data", rf_wdata, 32'h33);
    tick();
    check_output("bp_empty_we", rf_we, 0);

    // starvation: one entry, pipeline writes every cycle
    wb_wreg = 1'b1;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    tick();
    tick();
    tick();
    check_output("starve_3_blocked", stallreq, 0);
    tick();
    check_output("starve_4_blocked", stallreq, 1);
    tick();
    check_output("starve_hold", stallreq, 1);
    wb_wreg = 1'b0;
    #1;
    check_output("starve_bubble_stall", stallreq, 1);
    check_output("starve_bubble_waddr", rf_waddr, 9);
    check_output("starve_bubble_wdata", rf_wdata, 32'h99);
    tick();
    check_output("starve_cleared", stallreq, 0);
    check_output("starve_empty_we", rf_we, 0);

    // zero address accepted and dropped
    chk_a = 5'd0; chk_b = 5'd5; chk_d = 5'd0;
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h77;
    #1;
    check_output("zero_ready", lu_ready, 1);
    check_output("zero_busy_d", busy_d, 0);
    tick();
    lu_valid = 1'b0;
    #1;
    check_output("zero_no_write", rf_we, 0);
    lu_valid = 1'b1; lu_addr = 5'd4; lu_data = 32'h44;
    tick();
    lu_valid = 1'b0;
    chk_a = 5'd4;
    wb_wreg = 1'b1; wb_wd_addr = 5'd0; wb_wdata = 32'hDEAD;
    #1;
    check_output("sb_busy_a", busy_a, 1);
    check_output("sb_busy_b", busy_b, 0);
    check_output("sb_busy_d_zero", busy_d, 0);
    check_output("wb_zero_we", rf_we, 1);
    check_output("wb_zero_waddr", rf_waddr, 0);
    check_output("wb_zero_wdata", rf_wdata, 32'hDEAD);
    wb_wreg = 1'b0;
    tick();
    check_output("sb_entry4_drained", busy_a, 0);

    // reset mid-operation with two entries queued
    chk_a = 5'd6; chk_b = 5'd8;
    wb_wreg = 1'b1; wb_wd_addr = 5'd2; wb_wdata = 32'h55;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h66;
    tick();
    lu_addr = 5'd8; lu_data = 32'h88;
    tick();
    lu_valid = 1'b0;
    #1;
    check_output("mid_full", lu_ready, 0);
    check_output("mid_busy_a", busy_a, 1);
    rst = 1'b1;
    #1;
    check_output("mid_rst_ready", lu_ready, 0);
    check_output("mid_rst_we", rf_we, 0);
    check_output("mid_rst_busy_b", busy_b, 0);
    tick();
    rst = 1'b0; wb_wreg = 1'b0;
    #1;
    check_output("mid_after_ready", lu_ready, 1);
    check_output("mid_after_we", rf_we, 0);
    check_output("mid_after_busy_a", busy_a, 0);
    check_output("mid_after_busy_b", busy_b, 0);
    tick();
    check_output("mid_after2_we", rf_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the MEM/WB pipeline register (fixed latency);
  - a long-latency unit (divider/multi-cycle op, "lu") that delivers results asynchronously through a valid/ready handshake.
- Long-unit results are buffered in a small FIFO and drained into write-port idle slots.
- A pending-write scoreboard lets ID detect hazards.
- Asserts a stall request when a buffered result starves.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 4, consecutive blocked cycles before stallreq asserts; range 1..15.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- wb_wreg  in  1  pipeline write enable (from mem_wb)
- wb_wd_addr  in  AW  pipeline destination register
- wb_wdata  in  DW  pipeline write data
- lu_valid  in  1  long-unit result valid
- lu_addr  in  AW  long-unit destination register
- lu_data  in  DW  long-unit result
- lu_ready  out  1  arbiter can accept a long-unit result
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- chk_a, chk_b, chk_d  in  AW each  ID source A, source B and destination register for scoreboard lookup
- busy_a, busy_b, busy_d  out  1 each  corresponding register has a pending long-unit write
- stallreq  out  1  request to pipeline control for a write-back bubble

Behaviour:
- State:
  - FIFO storage of {addr, data};
  - rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH);
  - count (0..DEPTH);
  - age counter (4 bits, saturating);
  - stall flag.
- Reset (rst=1 at a clk edge):
  - count=0, pointers=0, age=0, stall flag=0.
  - All FIFO contents discarded, including any in-flight writes.
  - While rst=1: lu_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy_*=0, stallreq=0.
- Write-port priority (combinational, zero added latency):
  - Case 1, wb_wreg=1: rf_we=1, rf_waddr=wb_wd_addr, rf_wdata=wb_wdata. Pipeline always wins and is never delayed.
  - Case 2, wb_wreg=0 and count>0: rf_we=1 with the FIFO head entry; pop at the clk edge.
  - Case 3, otherwise: rf_we=0, rf_waddr=0, rf_wdata=0.
- Long-unit handshake:
  - lu_ready = (count<DEPTH) && !rst. It depends only on registered state, not on a same-cycle pop.
  - Transfer occurs when lu_valid && lu_ready at the edge.
  - lu_addr=0: the transfer is accepted but discarded (no push).
  - No bypass: an accepted result reaches rf_we no earlier than the cycle after acceptance.
  - Simultaneous push and pop: both happen and count is unchanged.
  - Full FIFO: lu_ready=0 and lu must hold valid/addr/data stable until accepted.
- Ordering:
  - Drain is strict FIFO order.
  - The arbiter never reorders or cancels entries.
  - WAW safety relies on ID stalling on busy_d.
- Scoreboard (combinational):
  - busy_x=1 iff chk_x≠0 and chk_x matches either:
    - the addr of any valid FIFO entry; or
    - lu_addr while lu_valid=1.
  - lu_valid alone is sufficient, even if lu_ready=0.
- Starvation:
  - age resets to 0 when count=0 or a pop occurs.
  - age increments (saturating at STARVE_LIMIT) each cycle that count>0 && wb_wreg=1.
  - stall flag sets at the edge where age+1 reaches STARVE_LIMIT; stallreq = stall flag.
  - stall flag clears at the edge of the next pop.
  - Pipeline control must deliver a wb_wreg=0 cycle; stallreq stays high until that occurs.
- Pipeline write to address 0 is passed through unchanged; the register file ignores it.

Test Plan:
- Reset mid-operation: push 2 entries, assert rst 1 cycle → count=0, lu_ready=0 during rst then 1, no rf_we from discarded entries, busy_*=0.
- Idle drain: wb_wreg=0; lu delivers addr=3, data=0x1234 at edge N → cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=0x1234; busy_a (chk_a=3) high from lu_valid through cycle N+1, low after.
- Priority: FIFO holds {7,0xAA}; wb_wreg=1 addr=2 data=0x55 for 2 cycles → rf writes 2/0x55 both cycles, then 7/0xAA on first wb_wreg=0 cycle.
- Full/back-pressure: DEPTH=2, wb_wreg=1 continuously, lu offers 3 results → first two accepted, lu_ready=0 with count=2, third held until the first pop; FIFO order 1,2,3 preserved at rf.
- Starvation: STARVE_LIMIT=4, count>0, wb_wreg=1 continuously → stallreq rises after 4 blocked cycles; one wb_wreg=0 cycle pops the head and stallreq falls at that edge.
- Zero-addr and scoreboard: lu_addr=0 accepted with no rf write; chk_d=0 → busy_d=0 even with entries pending.
